// File: rtl/cache_sim_pkg.sv
// Shared types and helpers for the cache simulator and its access-stream generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_sim_pkg;

    typedef logic [15:0] u16;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    // Run mode selected at start
    typedef enum logic {
        MODE_PLAY  = 1'b0,
        MODE_SWEEP = 1'b1
    } mode_e;

    // Generator control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SWEEP  = 2'd2,
        FINISH = 2'd3
    } gen_state_e;

    // Byte-select width for a line of `linesize` bits
    function automatic int bs_width(input int linesize);
        return $clog2(linesize >> 3);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace FIFO holding {rw, addr} entries for playback.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; a same-cycle pop never frees a slot for a push.
module trace_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [32:0]              push_dat,
    input  logic                     pop,
    output logic [32:0]              head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok, pop_ok;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; the head is only consumed while non-empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/cache_trace_gen.sv
// Access-stream generator: replays a loaded trace or sweeps strided line addresses into the cache simulator.
// Latency: first request one cycle after start is sampled; one access per cycle; done one cycle after the last transfer.
// Backpressure: request held stable while req_ready is low; loader stalled via ld_ready when the FIFO is full.
module cache_trace_gen
    import cache_sim_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int LINESIZE = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic                    ld_rw,
    input  logic [31:0]             ld_addr,
    input  logic                    start,
    input  logic                    mode,
    input  logic [31:0]             cfg_base,
    input  logic [15:0]             cfg_stride,
    input  logic [15:0]             cfg_count,
    input  logic                    cfg_rw,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    rw,
    output logic [31:0]             address,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [31:0]             issued_reads,
    output logic [31:0]             issued_writes
);

    localparam int BSW = bs_width(LINESIZE);
    localparam int LW  = $clog2(DEPTH) + 1;

    gen_state_e    state_q, state_d;
    u32            addr_q, addr_d;
    u32            step_q, step_d;
    u16            left_q, left_d;
    logic          cfg_rw_q, cfg_rw_d;
    u32            reads_q, reads_d;
    u32            writes_q, writes_d;

    logic          fifo_full, fifo_empty, fifo_push, fifo_pop, xfer;
    logic [32:0]   fifo_head;
    logic [LW-1:0] level;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat ({ld_rw, ld_addr}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign ld_ready      = !fifo_full;
    assign fifo_push     = ld_valid && ld_ready;
    assign xfer          = req_valid && req_ready;
    assign fifo_pop      = (state_q == PLAY) && xfer;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FINISH);
    assign fifo_level    = level;
    assign issued_reads  = reads_q;
    assign issued_writes = writes_q;

    // Request presentation; address/rw forced to zero whenever nothing is offered
    always_comb begin
        req_valid = 1'b0;
        rw        = 1'b0;
        address   = '0;
        if (state_q == PLAY && !fifo_empty) begin
            req_valid = 1'b1;
            {rw, address} = fifo_head;
        end else if (state_q == SWEEP) begin
            req_valid = 1'b1;
            rw        = cfg_rw_q;
            address   = addr_q;
        end
    end

    // Next-state, sweep accumulator and access counters
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        step_d   = step_q;
        left_d   = left_q;
        cfg_rw_d = cfg_rw_q;
        reads_d  = reads_q;
        writes_d = writes_q;

        if (xfer) begin
            if (rw) writes_d = writes_q + 1'b1;
            else    reads_d  = reads_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = cfg_base;
                    step_d   = u32'(cfg_stride) << BSW;
                    left_d   = cfg_count;
                    cfg_rw_d = cfg_rw;
                    if (mode_e'(mode) == MODE_PLAY) state_d = PLAY;
                    else if (cfg_count != '0)       state_d = SWEEP;
                    else                            state_d = FINISH;
                end
            end
            PLAY: begin
                // A push landing in the same cycle keeps the run alive
                if (fifo_empty && !fifo_push) begin
                    state_d = FINISH;
                end else if (xfer && level == LW'(1) && !fifo_push) begin
                    state_d = FINISH;
                end
            end
            SWEEP: begin
                if (xfer) begin
                    addr_d = addr_q + step_q;
                    left_d = left_q - 1'b1;
                    if (left_q == 16'd1) state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            step_q   <= '0;
            left_q   <= '0;
            cfg_rw_q <= 1'b0;
            reads_q  <= '0;
            writes_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            step_q   <= step_d;
            left_q   <= left_d;
            cfg_rw_q <= cfg_rw_d;
            reads_q  <= reads_d;
            writes_q <= writes_d;
        end
    end

endmodule

// File: tb/tb_cache_trace_gen.sv
// Bench for cache_trace_gen: expected accesses queued by stimulus, checked by an independent monitor.
// Latency: n/a.
// Backpressure: exercised by toggling req_ready and holding ld_valid against a full FIFO.
module tb_cache_trace_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, ld_ready, ld_rw;
    logic [31:0] ld_addr;
    logic        start, mode;
    logic [31:0] cfg_base;
    logic [15:0] cfg_stride, cfg_count;
    logic        cfg_rw;
    logic        req_valid, req_ready, rw;
    logic [31:0] address;
    logic        busy, done;
    logic [2:0]  fifo_level;
    logic [31:0] issued_reads, issued_writes;

    int n_cmp = 0;
    int n_err = 0;

    logic [32:0] sb [$];
    logic        prev_stall = 1'b0;
    logic        prev_rw;
    logic [31:0] prev_addr;
    logic        vld_seen = 1'b0;

    cache_trace_gen #(.DEPTH(4), .LINESIZE(128)) dut (
        .clk           (clk),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rw         (ld_rw),
        .ld_addr       (ld_addr),
        .start         (start),
        .mode          (mode),
        .cfg_base      (cfg_base),
        .cfg_stride    (cfg_stride),
        .cfg_count     (cfg_count),
        .cfg_rw        (cfg_rw),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .rw            (rw),
        .address       (address),
        .busy          (busy),
        .done          (done),
        .fifo_level    (fifo_level),
        .issued_reads  (issued_reads),
        .issued_writes (issued_writes)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted access must match the head of the expectation queue,
    // and a stalled access must be held unchanged into the next cycle
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (req_valid) vld_seen = 1'b1;
            if (prev_stall) begin
                check("stall_hold_valid", 64'(req_valid), 64'd1);
                check("stall_hold_req", 64'({rw, address}), 64'({prev_rw, prev_addr}));
            end
            if (req_valid && req_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_req: got rw=%0b addr=0x%0h, expected no request", rw, address);
                end else begin
                    check("req", 64'({rw, address}), 64'(sb.pop_front()));
                end
            end
            prev_stall = req_valid && !req_ready;
            prev_rw    = rw;
            prev_addr  = address;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic r, input logic [31:0] a);
        ld_valid = 1'b1;
        ld_rw    = r;
        ld_addr  = a;
        sb.push_back({r, a});
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic m, input logic [31:0] b, input logic [15:0] s,
                               input logic [15:0] c, input logic r);
        start      = 1'b1;
        mode       = m;
        cfg_base   = b;
        cfg_stride = s;
        cfg_count  = c;
        cfg_rw     = r;
        tick();
        start = 1'b0;
    endtask

    // Counts falling edges from now until done is seen (bounded), then steps past the FINISH cycle
    task automatic wait_done(input string name, input int exp_cyc);
        int  k;
        bit  seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 50) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        check(name, 64'(k), 64'(exp_cyc));
        tick();
        @(negedge clk);
        check({name, "_idle"}, 64'({busy, done}), 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_rw = 1'b0; ld_addr = '0;
        start = 1'b0; mode = 1'b0; cfg_base = '0; cfg_stride = '0; cfg_count = '0;
        cfg_rw = 1'b0; req_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        check("rst_outputs", 64'({req_valid, rw, busy, done}), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_counters", {issued_reads, issued_writes}, 64'd0);
        tick();

        // Playback of three entries at full throughput
        req_ready = 1'b1;
        push_entry(1'b0, 32'h100);
        push_entry(1'b1, 32'h180);
        push_entry(1'b0, 32'h100);
        pulse_start(1'b0, 32'h0, 16'd0, 16'd0, 1'b0);
        wait_done("play_done", 4);
        check("play_reads", 64'(issued_reads), 64'd2);
        check("play_writes", 64'(issued_writes), 64'd1);

        // Sweep wrapping through 2^32: step = 1 line = 16 bytes
        sb.push_back({1'b1, 32'hFFFF_FFF0});
        sb.push_back({1'b1, 32'h0000_0000});
        sb.push_back({1'b1, 32'h0000_0010});
        pulse_start(1'b1, 32'hFFFF_FFF0, 16'd1, 16'd3, 1'b1);
        wait_done("sweep_done", 4);
        check("sweep_writes", 64'(issued_writes), 64'd4);
        check("sweep_reads", 64'(issued_reads), 64'd2);

        // Backpressure: first entry held for four stalled cycles
        req_ready = 1'b0;
        push_entry(1'b0, 32'h200);
        push_entry(1'b1, 32'h240);
        pulse_start(1'b0, 32'h0, 16'd0, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_level", 64'(fifo_level), 64'd2);
            check("bp_head", 64'({req_valid, rw, address}), 64'({1'b1, 1'b0, 32'h200}));
            tick();
        end
        req_ready = 1'b1;
        wait_done("bp_done", 3);
        check("bp_counters", {issued_reads, issued_writes}, {32'd3, 32'd5});

        // Full FIFO: fifth entry waits for a pop
        req_ready = 1'b0;
        push_entry(1'b0, 32'h1000);
        push_entry(1'b1, 32'h1040);
        push_entry(1'b0, 32'h1080);
        push_entry(1'b0, 32'h10C0);
        ld_valid = 1'b1; ld_rw = 1'b1; ld_addr = 32'h1100;
        sb.push_back({1'b1, 32'h1100});
        @(negedge clk);
        check("full_ld_ready", 64'(ld_ready), 64'd0);
        check("full_level", 64'(fifo_level), 64'd4);
        tick();
        @(negedge clk);
        check("full_hold_level", 64'(fifo_level), 64'd4);
        tick();
        pulse_start(1'b0, 32'h0, 16'd0, 16'd0, 1'b0);
        req_ready = 1'b1;
        @(negedge clk);
        check("full_pop_cycle_ld_ready", 64'(ld_ready), 64'd0);
        tick();
        req_ready = 1'b0;
        @(negedge clk);
        check("full_after_pop_level", 64'(fifo_level), 64'd3);
        check("full_after_pop_ld_ready", 64'(ld_ready), 64'd1);
        tick();
        ld_valid = 1'b0;
        @(negedge clk);
        check("full_refill_level", 64'(fifo_level), 64'd4);
        tick();
        req_ready = 1'b1;
        wait_done("full_done", 5);
        check("full_counters", {issued_reads, issued_writes}, {32'd6, 32'd7});

        // Zero-length runs: empty playback goes through PLAY for one cycle,
        // a zero-count sweep goes straight to FINISH
        vld_seen = 1'b0;
        pulse_start(1'b0, 32'h0, 16'd0, 16'd0, 1'b0);
        wait_done("empty_play_done", 2);
        pulse_start(1'b1, 32'h4000, 16'd1, 16'd0, 1'b0);
        wait_done("zero_sweep_done", 1);
        check("zero_len_no_req", 64'(vld_seen), 64'd0);
        check("zero_len_counters", {issued_reads, issued_writes}, {32'd6, 32'd7});

        // Reset after the fourth sweep transfer (step = 2 lines = 0x20 bytes)
        sb.push_back({1'b0, 32'h1000});
        sb.push_back({1'b0, 32'h1020});
        sb.push_back({1'b0, 32'h1040});
        sb.push_back({1'b0, 32'h1060});
        pulse_start(1'b1, 32'h1000, 16'd2, 16'd10, 1'b0);
        repeat (4) tick();
        reset = 1'b1;
        @(negedge clk);
        check("pre_reset_reads", 64'(issued_reads), 64'd10);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_state", 64'({busy, req_valid, done}), 64'd0);
        check("mid_reset_counters", {issued_reads, issued_writes}, 64'd0);
        check("mid_reset_level", 64'(fifo_level), 64'd0);
        begin
            bit done_seen;
            done_seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (done) done_seen = 1'b1;
            end
            check("mid_reset_no_done", 64'(done_seen), 64'd0);
        end

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
